// File: rtl/mul_unit_if.sv
// Request/result bundle between the issue logic and the multiply unit.
// master drives operands and Start; slave returns Busy/Done/result/flags.
interface mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Long;
  logic             Signed;
  logic             Accumulate;
  logic [WIDTH-1:0] Rm;
  logic [WIDTH-1:0] Rs;
  logic [WIDTH-1:0] AccHi;
  logic [WIDTH-1:0] AccLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultHi;
  logic [WIDTH-1:0] ResultLo;
  logic             FlagN;
  logic             FlagZ;

  modport master (
    output Start, Long, Signed, Accumulate,
    output Rm, Rs, AccHi, AccLo,
    input  Busy, Done, ResultHi, ResultLo,
    input  FlagN, FlagZ
  );

  modport slave (
    input  Start, Long, Signed, Accumulate,
    input  Rm, Rs, AccHi, AccLo,
    output Busy, Done, ResultHi, ResultLo,
    output FlagN, FlagZ
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiply / multiply-accumulate unit.
// Signed long ops multiply magnitudes and negate the product at the end.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input logic       CLK,
  input logic       RESETn,
  mul_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINAL
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             long_q;
  logic             acc_q;
  logic             neg_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mplier;
  logic [W2-1:0]    mcand;
  logic [W2-1:0]    prod;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             flag_n;
  logic             flag_z;

  logic             sgn_long;
  logic [WIDTH-1:0] rm_mag;
  logic [WIDTH-1:0] rs_mag;
  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    acc_w;
  logic [W2-1:0]    sum;

  assign sgn_long = bus.Signed & bus.Long;
  // 0x80000000 negates to itself, which is 2^31 read unsigned
  assign rm_mag = (sgn_long & bus.Rm[WIDTH-1]) ? -bus.Rm : bus.Rm;
  assign rs_mag = (sgn_long & bus.Rs[WIDTH-1]) ? -bus.Rs : bus.Rs;

  always_comb begin
    prod_s = neg_q ? -prod : prod;
    acc_w  = long_q ? {acc_hi, acc_lo}
                    : {{WIDTH{1'b0}}, acc_lo};
    sum    = acc_q ? prod_s + acc_w : prod_s;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state  <= IDLE;
      cnt    <= '0;
      long_q <= 1'b0;
      acc_q  <= 1'b0;
      neg_q  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      mplier <= '0;
      mcand  <= '0;
      prod   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            long_q <= bus.Long;
            acc_q  <= bus.Accumulate;
            neg_q  <= sgn_long & (bus.Rm[WIDTH-1] ^ bus.Rs[WIDTH-1]);
            acc_hi <= bus.AccHi;
            acc_lo <= bus.AccLo;
            mcand  <= {{WIDTH{1'b0}}, rm_mag};
            mplier <= rs_mag;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FINAL;
        end
        FINAL: begin
          res_lo <= sum[WIDTH-1:0];
          res_hi <= long_q ? sum[W2-1:WIDTH] : '0;
          flag_n <= long_q ? sum[W2-1] : sum[WIDTH-1];
          flag_z <= long_q ? (sum == '0)
                           : (sum[WIDTH-1:0] == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.ResultHi = res_hi;
  assign bus.ResultLo = res_lo;
  assign bus.FlagN    = flag_n;
  assign bus.FlagZ    = flag_z;
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative 32x32 multiply / multiply-accumulate unit in the execute stage, beside the operand Shifter.
- Register operands Rm/Rs are read in the same decode slot that feeds the Shifter.
- Covers MUL, MLA, UMULL, SMULL, UMLAL and SMLAL.
- Radix-2 shift-add datapath over WIDTH cycles; the control unit stalls the processor while Busy is high.
- Result and NZ flags are handed to the writeback/flag mux alongside the ALU/Shifter result.

Parameters:
- WIDTH, 32, operand width; the counter width is clog2(WIDTH). Only 32 is required.

Ports:
- CLK  input  1  rising-edge clock
- RESETn  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only in IDLE
- Long  input  1  1: 64-bit result (xMULL/xMLAL); 0: 32-bit result (MUL/MLA)
- Signed  input  1  1: two's-complement operands (SMULL/SMLAL); ignored when Long=0
- Accumulate  input  1  1: add {AccHi,AccLo} (Long) or AccLo (short) to the product
- Rm  input  WIDTH  multiplicand
- Rs  input  WIDTH  multiplier
- AccHi  input  WIDTH  accumulate high word (RdHi); ignored when Long=0
- AccLo  input  WIDTH  accumulate low word (Rn or RdLo)
- Busy  output  1  high while an operation is in flight
- Done  output  1  one-cycle pulse; result valid
- ResultHi  output  WIDTH  product bits 63:32; 0 when Long=0
- ResultLo  output  WIDTH  product bits 31:0
- FlagN  output  1  sign of the result
- FlagZ  output  1  result equals zero

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESETn.
- Reset state: IDLE, Busy=0, Done=0, ResultHi=0, ResultLo=0, FlagN=0, FlagZ=0, counter=0.
- States: IDLE, CALC, FINAL.
- IDLE with Start=1 at edge k:
  - latch Long, Signed, Accumulate, AccHi and AccLo;
  - load magnitude registers: |Rm| and |Rs| when Long&Signed, otherwise raw values; 0x80000000 gives magnitude 2^31;
  - latch NegProd = Signed&Long&(Rm[31]^Rs[31]);
  - clear the 64-bit partial product and the counter; go to CALC.
  - Busy=1 from edge k.
- CALC, one iteration per cycle:
  - if multiplier LSB is 1, add the multiplicand (shifted by the counter position) into the 64-bit partial product;
  - shift the multiplier right; counter++.
  - After WIDTH iterations (counter wraps from WIDTH-1) go to FINAL.
- FINAL, one cycle:
  - if NegProd, two's-complement negate the 64-bit product;
  - if Accumulate, add the accumulator: 64-bit add for Long, 32-bit add for short with carry into bit 32 discarded;
  - register ResultHi/ResultLo; ResultHi forced to 0 when Long=0;
  - flags: FlagN = bit63 (Long) or bit31 (short); FlagZ = all 64 bits zero (Long) or low 32 bits zero (short);
  - Done=1 for the following cycle; Busy=0; return to IDLE.
- Latency:
  - Start at edge k → Busy high for edges k..k+WIDTH; Done high in the cycle after edge k+WIDTH+1 (34 cycles for WIDTH=32).
  - Busy and Done are never high together.
- Hold: Result and flags hold until the FINAL of the next operation. They are not cleared at Start.
- Start while Busy=1: ignored. Operands and mode are not re-sampled.
- Start during the Done cycle (state is IDLE): accepted. Back-to-back throughput is one result per WIDTH+2 cycles.
- Wrap-around: short results are modulo 2^32; long results are modulo 2^64. No overflow flag. FlagC/FlagV are not produced; the flag mux preserves them.
- Reset mid-operation: immediate return to IDLE with all outputs zero. No Done pulse for the aborted operation.
- Operand inputs may change after the Start edge without effect.

Test Plan:
- MUL Rm=7, Rs=6, Long=0 → Done 34 cycles after Start; ResultLo=0x0000002A, ResultHi=0, N=0, Z=0; Busy high for exactly 33 cycles.
- UMULL Rm=Rs=0xFFFFFFFF → ResultHi=0xFFFFFFFE, ResultLo=0x00000001, N=1, Z=0.
- SMULL Rm=0xFFFFFFFF, Rs=0x00000002 → ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFFE, N=1. Also SMULL 0x80000000*0x80000000 → ResultHi=0x40000000, ResultLo=0.
- MLA 0x00010000*0x00010000 + AccLo=0 → ResultLo=0 (wrap), Z=1. UMLAL 2*3 + {AccHi=1, AccLo=0xFFFFFFFF} → ResultHi=0x00000002, ResultLo=0x00000005.
- Start pulsed with new operands at cycle 10 of a MUL 3*5 → ignored, ResultLo=15. RESETn low at cycle 20 of a second operation → Busy=0, Result=0, no Done; the next Start completes normally.
- Start held high through the Done cycle → second operation accepted on the Done edge; its Done follows 34 cycles after the first Done.
